uart_mmio_ctrl: RTL

- Memory-mapped controller between the single-cycle CPU data bus and uart_peripheral.
- Buffers CPU TX writes in a 16-entry FIFO and sequences them into the UART transmitter one byte at a time.
- Pops RX bytes on CPU reads, owns the baud (clk_per_bit) configuration, and raises an interrupt.

---
 rtl/uart_mmio_ctrl_pkg.sv | 20 ++
 rtl/fifo_buffer_16.sv | 25 ++
 rtl/uart_mmio_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_mmio_ctrl_pkg.sv
// uart_mmio_ctrl_pkg: register map, bit positions and TX FSM encoding shared by the UART MMIO controller.
package uart_mmio_ctrl_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    localparam int ST_RX_READY  = 0;
    localparam int ST_TX_BUSY   = 1;
    localparam int ST_TXF_EMPTY = 2;
    localparam int ST_TXF_FULL  = 3;
    localparam int ST_TX_DROP   = 4;
    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_RX_IE  = 1;
    localparam int CTRL_TXE_IE = 2;
    localparam logic [15:0] DEFAULT_CLK_PER_BIT = 16'd868;
    typedef enum logic [1:0] {IDLE, LAUNCH, LAUNCH_WAIT, SENDING} tx_state_t;
    function automatic logic [15:0] clamp_baud(input logic [15:0] v, input logic [15:0] lo);
        return (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/fifo_buffer_16.sv
// fifo_buffer_16: 16x8 storage with head-of-queue output; occupancy is tracked by the owner.
module fifo_buffer_16 (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    logic [7:0] mem [16];
    logic [3:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + 4'(push);
            rd_ptr <= rd_ptr + 4'(pop);
        end
    end
    assign dout = mem[rd_ptr];
endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: CPU bus registers for the UART; buffers TX bytes, pops RX bytes, owns baud and irq.
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter logic [15:0] MIN_CLK_PER_BIT = 16'd4,
    parameter int          BUSY_TIMEOUT    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic        uart_tx_start,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_busy,
    output logic        uart_read_rx,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_ready,
    output logic [15:0] uart_clk_per_bit
);
    tx_state_t   state, state_n;
    logic [1:0]  reg_sel;
    logic        wr, rd, push_req, txf_push, txf_pop, txf_empty, txf_full, tx_busy;
    logic [4:0]  txf_cnt;
    logic [7:0]  wait_cnt;
    logic [15:0] baud_shadow;
    logic        tx_en, rx_ie, txe_ie, tx_drop;
    logic [31:0] status;
    logic        unused_bits;

    assign reg_sel   = bus_addr[3:2];
    assign wr        = bus_sel & bus_we;
    assign rd        = bus_sel & bus_re;
    assign txf_empty = (txf_cnt == 5'd0);
    assign txf_full  = (txf_cnt == 5'd16);
    assign txf_pop   = (state == LAUNCH);
    assign push_req  = wr && reg_sel == REG_DATA;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted then.
    assign txf_push  = push_req && (!txf_full || txf_pop);
    assign tx_busy   = (state != IDLE) || uart_tx_busy;
    assign status    = {27'b0, tx_drop, txf_full, txf_empty, tx_busy, uart_rx_ready};
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

    fifo_buffer_16 u_txf (
        .clk   (clk),
        .reset (reset),
        .push  (txf_push),
        .pop   (txf_pop),
        .din   (bus_wdata[7:0]),
        .dout  (uart_tx_data)
    );

    always_comb begin
        state_n       = state;
        uart_tx_start = 1'b0;
        case (state)
            IDLE:        state_n = (tx_en && !txf_empty && !uart_tx_busy) ? LAUNCH : IDLE;
            LAUNCH: begin
                uart_tx_start = 1'b1;
                state_n       = LAUNCH_WAIT;
            end
            LAUNCH_WAIT: state_n = uart_tx_busy ? SENDING :
                                   (wait_cnt == 8'(BUSY_TIMEOUT - 1)) ? IDLE : LAUNCH_WAIT;
            SENDING:     state_n = uart_tx_busy ? SENDING : IDLE;
            default:     state_n = IDLE;
        endcase
    end

    always_comb begin
        bus_rdata    = !rd ? 32'b0 :
                       reg_sel == REG_DATA   ? {24'b0, uart_rx_data} :
                       reg_sel == REG_STATUS ? status :
                       reg_sel == REG_BAUD   ? {16'b0, baud_shadow} :
                                               {29'b0, txe_ie, rx_ie, tx_en};
        uart_read_rx = rd && reg_sel == REG_DATA && uart_rx_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            txf_cnt          <= '0;
            wait_cnt         <= '0;
            baud_shadow      <= DEFAULT_CLK_PER_BIT;
            uart_clk_per_bit <= DEFAULT_CLK_PER_BIT;
            tx_en            <= 1'b1;
            rx_ie            <= 1'b0;
            txe_ie           <= 1'b0;
            tx_drop          <= 1'b0;
            irq              <= 1'b0;
        end else begin
            state    <= state_n;
            txf_cnt  <= txf_cnt + 5'(txf_push) - 5'(txf_pop);
            wait_cnt <= (state == LAUNCH_WAIT) ? wait_cnt + 8'd1 : 8'd0;
            if (push_req && !txf_push)
                tx_drop <= 1'b1;
            else if (wr && reg_sel == REG_STATUS && bus_wdata[ST_TX_DROP])
                tx_drop <= 1'b0;
            if (wr && reg_sel == REG_BAUD)
                baud_shadow <= clamp_baud(bus_wdata[15:0], MIN_CLK_PER_BIT);
            // Divisor only changes between frames so an in-flight byte keeps its timing.
            if (state == IDLE && !uart_tx_busy)
                uart_clk_per_bit <= baud_shadow;
            if (wr && reg_sel == REG_CTRL) begin
                tx_en  <= bus_wdata[CTRL_TX_EN];
                rx_ie  <= bus_wdata[CTRL_RX_IE];
                txe_ie <= bus_wdata[CTRL_TXE_IE];
            end
            irq <= (rx_ie & uart_rx_ready) | (txe_ie & txf_empty & (state == IDLE));
        end
    end
endmodule
